// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
// Shared types and constants for the event arbiter path.
//   POLARITY     : width of the one-hot polarity request bus
//   dec_state_t  : replay FSM states of polarity_event_decoder
//   REQ_ON/OFF/IDLE : one-hot request encodings driven to the event sink
//   pol_to_req() : expands a 1-bit polarity into the one-hot request code
// -----------------------------------------------------------------------------
package arbiter_pkg;

   localparam int POLARITY = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2
   } dec_state_t;

   localparam logic [POLARITY-1:0] REQ_ON   = 2'b10;
   localparam logic [POLARITY-1:0] REQ_OFF  = 2'b01;
   localparam logic [POLARITY-1:0] REQ_IDLE = 2'b00;

   // A single polarity bit can only ever produce ON or OFF, never 2'b11.
   function automatic logic [POLARITY-1:0] pol_to_req(input logic pol);
      logic [POLARITY-1:0] code;
      if (pol) begin
         code = REQ_ON;
      end else begin
         code = REQ_OFF;
      end
      return code;
   endfunction

endpackage

// File: rtl/pol_event_fifo.sv
// -----------------------------------------------------------------------------
// pol_event_fifo
// Synchronous FIFO buffering {address, polarity} events ahead of the replay FSM.
// Pushes are ignored when full and pops are ignored when empty. The head entry
// is presented combinationally on rdata_o.
//   clk_i     : clock
//   reset_n_i : synchronous active-low reset (clears pointers and count)
//   push_i    : write wdata_i if not full
//   pop_i     : advance the read pointer if not empty
//   wdata_i   : entry to write
//   rdata_o   : current head entry
//   count_o   : occupancy, 0..DEPTH
//   full_o    : count == DEPTH
//   empty_o   : count == 0
// DEPTH must be a power of 2 (>= 2) so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module pol_event_fifo #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DATA_W-1:0]          wdata_i,
   output logic [DATA_W-1:0]          rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              full_s;
   logic              empty_s;
   logic              do_push_s;
   logic              do_pop_s;

   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign empty_s   = (count_r == {CNT_W{1'b0}});
   assign do_push_s = push_i && !full_s;
   assign do_pop_s  = pop_i && !empty_s;

   // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata_i;
      end
   end

   assign rdata_o = mem_r[rd_ptr_r];
   assign count_o = count_r;
   assign full_o  = full_s;
   assign empty_o = empty_s;

endmodule

// File: rtl/polarity_event_decoder.sv
// -----------------------------------------------------------------------------
// polarity_event_decoder
// Buffers {address, polarity} events and replays each one to an event sink over
// a 4-phase req/ack handshake, re-expanding polarity to one-hot (10=ON, 01=OFF).
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   evt_valid_i/evt_ready_o/evt_addr_i/evt_pol_i : upstream event interface
//   req_o, addr_o    : registered one-hot request and its address to the sink
//   ack_i            : sink acknowledge
//   busy_o           : FSM not IDLE or FIFO non-empty
//   fifo_count_o     : FIFO occupancy
//   timeout_err_o    : sticky timeout flag
// Optional feature macro: POL_DEC_TIMEOUT_EN. When defined, a request that sees
// no ack for TIMEOUT_CYCLES cycles is dropped and timeout_err_o sets until reset.
// When undefined, REQ waits indefinitely and timeout_err_o is tied low.
// -----------------------------------------------------------------------------
module polarity_event_decoder
   import arbiter_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         evt_valid_i,
   output logic                         evt_ready_o,
   input  logic [ADDR_W-1:0]            evt_addr_i,
   input  logic                         evt_pol_i,
   output logic [POLARITY-1:0]          req_o,
   output logic [ADDR_W-1:0]            addr_o,
   input  logic                         ack_i,
   output logic                         busy_o,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
   output logic                         timeout_err_o
);

   localparam int ENTRY_W = ADDR_W + 1;

   // Reject configurations the pointer arithmetic and timeout compare cannot support.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   dec_state_t           state_r;
   logic [POLARITY-1:0]  req_r;
   logic [ADDR_W-1:0]    addr_r;
   logic [ENTRY_W-1:0]   head_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic                 pop_s;
   logic                 tmo_expire_s;

   // Only an idle FSM consumes the FIFO head.
   assign pop_s = (state_r == IDLE) && !fifo_empty_s;

   pol_event_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (evt_valid_i),
      .pop_i     (pop_s),
      .wdata_i   ({evt_addr_i, evt_pol_i}),
      .rdata_o   (head_s),
      .count_o   (fifo_count_o),
      .full_o    (fifo_full_s),
      .empty_o   (fifo_empty_s)
   );

`ifdef POL_DEC_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_r;
   logic             tmo_err_r;

   // The counter holds (REQ cycles elapsed - 1); ack in the final cycle still wins.
   assign tmo_expire_s = (state_r == REQ) && !ack_i && (tmo_cnt_r == TMO_LAST);

   // REQ-cycle counter, cleared on REQ entry, plus the sticky error flag.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
         tmo_err_r <= 1'b0;
      end else begin
         if (pop_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
         end else if (state_r == REQ && !tmo_expire_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         end else begin
            tmo_cnt_r <= tmo_cnt_r;
         end
         if (tmo_expire_s) begin
            tmo_err_r <= 1'b1;
         end else begin
            tmo_err_r <= tmo_err_r;
         end
      end
   end

   assign timeout_err_o = tmo_err_r;
`else
   assign tmo_expire_s  = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

   // Replay FSM: request outputs are registered so req_o/addr_o are glitch-free
   // and cannot change while a request is being presented.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
         req_r   <= REQ_IDLE;
         addr_r  <= {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  state_r <= REQ;
                  req_r   <= pol_to_req(head_s[0]);
                  addr_r  <= head_s[ENTRY_W-1:1];
               end else begin
                  state_r <= IDLE;
                  req_r   <= REQ_IDLE;
               end
            end
            REQ: begin
               if (ack_i) begin
                  state_r <= RELEASE;
                  req_r   <= REQ_IDLE;
               end else if (tmo_expire_s) begin
                  state_r <= IDLE;
                  req_r   <= REQ_IDLE;
               end else begin
                  state_r <= REQ;
               end
            end
            RELEASE: begin
               req_r <= REQ_IDLE;
               if (!ack_i) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= RELEASE;
               end
            end
            default: begin
               state_r <= IDLE;
               req_r   <= REQ_IDLE;
            end
         endcase
      end
   end

   assign req_o       = req_r;
   assign addr_o      = addr_r;
   assign evt_ready_o = !fifo_full_s;
   assign busy_o      = (state_r != IDLE) || !fifo_empty_s;

endmodule
